// File: rtl/modexp_sequencer_if.sv
// Bus bundle for modexp_sequencer: the start/result control side plus the
// request/response handshake to the shared modular multiplier.
// slave  = the sequencer's view, master = the controller/multiplier side.
interface modexp_sequencer_if #(
  parameter int W  = 32,
  parameter int EW = 32
);
  logic          start;
  logic [W-1:0]  base;
  logic [EW-1:0] exp;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  result;
  logic          mm_start;
  logic [W-1:0]  mm_a;
  logic [W-1:0]  mm_b;
  logic [W-1:0]  mm_result;
  logic          mm_done;

  modport slave (
    input  start, base, exp, mm_result, mm_done,
    output busy, done, err, result, mm_start, mm_a, mm_b
  );

  modport master (
    output start, base, exp, mm_result, mm_done,
    input  busy, done, err, result, mm_start, mm_a, mm_b
  );
endinterface

// File: rtl/modexp_sequencer.sv
// modexp_sequencer: left-to-right square-and-multiply sequencer computing
// base^exp mod n through an external modular multiplier that owns n.
// Optional feature: define MODEXP_TIMEOUT_EN to abort a multiplier wait
// after TIMEOUT cycles (result forced to 0, err pulses with done).
module modexp_sequencer #(
  parameter int W       = 32,
  parameter int EW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  modexp_sequencer_if.slave bus
);
  localparam int CW = $clog2(EW + 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("modexp_sequencer: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE, SCAN, NEXT, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, DONE
  } state_t;

  state_t        state, state_nx;
  logic [W-1:0]  acc, acc_nx;
  logic [W-1:0]  b, b_nx;
  logic [EW-1:0] e, e_nx;
  logic [CW-1:0] cnt, cnt_nx;

`ifdef MODEXP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wcnt, wcnt_nx;
  logic          to_flag, to_nx;
`endif

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      b     <= '0;
      e     <= '0;
      cnt   <= '0;
`ifdef MODEXP_TIMEOUT_EN
      wcnt    <= '0;
      to_flag <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      b     <= b_nx;
      e     <= e_nx;
      cnt   <= cnt_nx;
`ifdef MODEXP_TIMEOUT_EN
      wcnt    <= wcnt_nx;
      to_flag <= to_nx;
`endif
    end
  end

  // Next-state and datapath updates. The exponent is consumed MSB-first by
  // shifting e left; cnt tracks how many bits are still unconsumed.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    b_nx     = b;
    e_nx     = e;
    cnt_nx   = cnt;
`ifdef MODEXP_TIMEOUT_EN
    wcnt_nx = wcnt;
    to_nx   = to_flag;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          b_nx     = bus.base;
          e_nx     = bus.exp;
          cnt_nx   = CW'(EW);
          acc_nx   = '0;
          state_nx = SCAN;
`ifdef MODEXP_TIMEOUT_EN
          to_nx = 1'b0;
`endif
        end
      end
      SCAN: begin
        // Leading zeros cost one cycle each; the first 1 seeds acc with b.
        e_nx   = {e[EW-2:0], 1'b0};
        cnt_nx = cnt - CW'(1);
        if (e[EW-1]) begin
          acc_nx   = b;
          state_nx = NEXT;
        end else if (cnt == CW'(1)) begin
          acc_nx   = W'(1);
          state_nx = DONE;
        end
      end
      NEXT: begin
        state_nx = (cnt == '0) ? DONE : SQR_REQ;
      end
      SQR_REQ: begin
        state_nx = SQR_WAIT;
`ifdef MODEXP_TIMEOUT_EN
        wcnt_nx = '0;
`endif
      end
      SQR_WAIT: begin
        if (bus.mm_done) begin
          acc_nx = bus.mm_result;
          // Bit stays in e[EW-1] until the multiply step consumes it.
          if (e[EW-1]) begin
            state_nx = MUL_REQ;
          end else begin
            e_nx     = {e[EW-2:0], 1'b0};
            cnt_nx   = cnt - CW'(1);
            state_nx = NEXT;
          end
        end
`ifdef MODEXP_TIMEOUT_EN
        else if (wcnt == TO_LAST) begin
          acc_nx   = '0;
          to_nx    = 1'b1;
          state_nx = DONE;
        end else begin
          wcnt_nx = wcnt + TW'(1);
        end
`endif
      end
      MUL_REQ: begin
        state_nx = MUL_WAIT;
`ifdef MODEXP_TIMEOUT_EN
        wcnt_nx = '0;
`endif
      end
      MUL_WAIT: begin
        if (bus.mm_done) begin
          acc_nx   = bus.mm_result;
          e_nx     = {e[EW-2:0], 1'b0};
          cnt_nx   = cnt - CW'(1);
          state_nx = NEXT;
        end
`ifdef MODEXP_TIMEOUT_EN
        else if (wcnt == TO_LAST) begin
          acc_nx   = '0;
          to_nx    = 1'b1;
          state_nx = DONE;
        end else begin
          wcnt_nx = wcnt + TW'(1);
        end
`endif
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs decode straight from state; operands come from registers that
  // only change on an accepted mm_done, so they are stable across a wait.
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.result   = acc;
  assign bus.mm_start = (state == SQR_REQ) || (state == MUL_REQ);
  assign bus.mm_a     = acc;
  assign bus.mm_b     = ((state == MUL_REQ) || (state == MUL_WAIT)) ? b : acc;
`ifdef MODEXP_TIMEOUT_EN
  assign bus.err = (state == DONE) && to_flag;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_modexp_sequencer.sv
// Self-checking bench for modexp_sequencer: a mod-97 multiplier model with
// latency 3 and a square-and-multiply reference computed arithmetically.
module tb_modexp_sequencer;
  localparam int W  = 32;
  localparam int EW = 32;
  localparam int TO = 15;
  localparam int L  = 3;
  localparam logic [63:0] NMOD = 64'd97;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  modexp_sequencer_if #(.W(W), .EW(EW)) bus();
  modexp_sequencer #(.W(W), .EW(EW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;
  bit mute = 1'b0;
  int cd = 0;
  logic [63:0] pairs[$];
  logic [63:0] exp_pairs[$];

  function automatic logic [31:0] mulmod(input logic [31:0] a, input logic [31:0] c);
    logic [63:0] p;
    p = 64'(a) * 64'(c);
    return 32'(p % NMOD);
  endfunction

  // Multiplier model: responds L cycles after mm_start using the operands
  // present at response time, so unstable operands corrupt the answer.
  always @(negedge clk) begin
    bus.mm_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.mm_done   = 1'b1;
        bus.mm_result = mulmod(bus.mm_a, bus.mm_b);
      end
    end
    if (bus.mm_start === 1'b1) begin
      pairs.push_back({bus.mm_a, bus.mm_b});
      if (!mute) cd = L;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: left-to-right binary exponentiation, listing the operand
  // pairs the multiplier should see.
  task automatic ref_model(input logic [31:0] bs, input logic [31:0] ex, output logic [31:0] res);
    logic [31:0] a;
    int m;
    exp_pairs.delete();
    if (ex == 0) begin
      res = 32'd1;
      return;
    end
    m = 31;
    while (!ex[m]) m--;
    a = bs;
    for (int i = m - 1; i >= 0; i--) begin
      exp_pairs.push_back({a, a});
      a = mulmod(a, a);
      if (ex[i]) begin
        exp_pairs.push_back({a, bs});
        a = mulmod(a, bs);
      end
    end
    res = a;
  endtask

  // Leaves the bench at the negedge of cycle 1 after the start-sampling edge.
  task automatic do_start(input logic [31:0] bs, input logic [31:0] ex);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = bs;
    bus.exp   = ex;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_pairs(input string tag, input int p0);
    bit ok;
    ok = (pairs.size() - p0 == exp_pairs.size());
    for (int i = 0; ok && i < exp_pairs.size(); i++)
      if (pairs[p0 + i] !== exp_pairs[i]) ok = 1'b0;
    chk({tag, "_ops_cnt"}, 64'(pairs.size() - p0), 64'(exp_pairs.size()));
    chk({tag, "_ops_seq"}, 64'(ok), 64'd1);
  endtask

  task automatic run_check(input string tag, input logic [31:0] bs, input logic [31:0] ex);
    logic [31:0] r;
    int p0, cyc;
    ref_model(bs, ex, r);
    p0 = pairs.size();
    do_start(bs, ex);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(cyc);
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_result"}, 64'(bus.result), 64'(r));
    chk({tag, "_err"}, 64'(bus.err), 64'd0);
    check_pairs(tag, p0);
    @(negedge clk);
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
    chk({tag, "_hold"}, 64'(bus.result), 64'(r));
  endtask

  initial begin
    logic [31:0] r;
    int p0, cyc, first, ndone, k;
    bit seen;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.base = '0;
    bus.exp = '0;
    bus.mm_done = 1'b0;
    bus.mm_result = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_mm_start", 64'(bus.mm_start), 64'd0);
    chk("rst_mm_ab", {bus.mm_a, bus.mm_b}, 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    reset = 1'b0;

    // Directed 4^13 mod 97 = 93 via sq, mul, sq, sq, mul.
    run_check("dir13", 32'd4, 32'd13);
    chk("dir13_93", 64'(bus.result), 64'd93);

    // Zero exponent: done only in cycle 33 after the start edge.
    p0 = pairs.size();
    do_start(32'd55, 32'd0);
    first = 0; ndone = 0;
    for (k = 1; k <= 40; k++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (first == 0) first = k;
      end
      if (k < 40) @(negedge clk);
    end
    chk("zexp_done_cycle", 64'(first), 64'd33);
    chk("zexp_done_count", 64'(ndone), 64'd1);
    chk("zexp_result", 64'(bus.result), 64'd1);
    chk("zexp_no_mm", 64'(pairs.size() - p0), 64'd0);

    run_check("uexp", 32'd5, 32'd1);
    p0 = pairs.size();
    run_check("msb", 32'd2, 32'h8000_0000);
    chk("msb_31sq", 64'(pairs.size() - p0), 64'd31);

    // Start while busy is ignored.
    p0 = pairs.size();
    do_start(32'd4, 32'd13);
    repeat (6) @(negedge clk);
    bus.start = 1'b1; bus.base = 32'd7; bus.exp = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    chk("busy_start_result", 64'(bus.result), 64'd93);
    chk("busy_start_ops", 64'(pairs.size() - p0), 64'd5);

    // Back-to-back: start in the first idle cycle after done.
    @(negedge clk);
    chk("b2b_idle", 64'(bus.busy), 64'd0);
    ref_model(32'd3, 32'd5, r);
    bus.start = 1'b1; bus.base = 32'd3; bus.exp = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(cyc);
    chk("b2b_result", 64'(bus.result), 64'(r));
    @(negedge clk);

    // Randomized operands against the reference.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] bs, ex;
      bs = 32'($urandom_range(0, 96));
      ex = $urandom;
      if (i % 2 == 1) ex = ex >> $urandom_range(8, 30);
      run_check($sformatf("rnd%0d", i), bs, ex);
    end

    // Reset during SQR_WAIT; the in-flight response lands in IDLE.
    p0 = pairs.size();
    do_start(32'd4, 32'd13);
    k = 0;
    while (bus.mm_start !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid_sqr_seen", 64'(bus.mm_start), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_busy", 64'(bus.busy), 64'd0);
    chk("rstmid_result", 64'(bus.result), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'd0) seen = 1'b1;
      @(negedge clk);
    end
    chk("rstmid_quiet", 64'(seen), 64'd0);
    chk("rstmid_ops", 64'(pairs.size() - p0), 64'd1);

    // Multiplier never answers.
    mute = 1'b1;
    do_start(32'd4, 32'd13);
    k = 0;
    while (bus.mm_start !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
`ifdef MODEXP_TIMEOUT_EN
    k = 0;
    while (bus.done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycle", 64'(k), 64'd16);
    chk("to_err", 64'(bus.err), 64'd1);
    chk("to_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    chk("to_err_pulse", 64'(bus.err), 64'd0);
    chk("to_idle", 64'(bus.busy), 64'd0);
`else
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.err !== 1'b0 || bus.done !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk("hang_busy", 64'(bus.busy), 64'd1);
    chk("hang_no_err", 64'(seen), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
    mute = 1'b0;
    run_check("recover", 32'd10, 32'd77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
